mul_share_arbiter: RTL and testbench

- Shares one `multiplier` instance between NREQ requesters.
- Arbitrates incoming requests round-robin and latches the winner's operands.
- Sequences the multiplier's req/rdy/done handshake and routes the product back to the winning requester.
- Sits between client blocks and the multiplier. A watchdog recovers from a multiplier that never completes.

---
 rtl/mul_share_arbiter.sv | 106 ++++++++++
 tb/tb_mul_share_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one multiplier among NREQ requesters,
// with req/rdy/done sequencing, product routing and a watchdog abort.
module mul_share_arbiter #(
    parameter int WIDTH   = 5,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       cli_req,
    input  logic [NREQ*WIDTH-1:0] cli_a,
    input  logic [NREQ*WIDTH-1:0] cli_b,
    output logic [NREQ-1:0]       cli_gnt,
    output logic [NREQ-1:0]       cli_done,
    output logic [2*WIDTH-1:0]    cli_ab,
    output logic                  err,
    output logic                  busy,
    output logic                  mul_req,
    input  logic                  mul_rdy,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_ab
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, r_id, w_pick, w_idx;
    logic [CW-1:0] r_cnt;
    logic          w_tc, w_grant, w_xfer, w_cap, w_abort;

    // Later assignments win, so the loop runs downward to keep the first hit from r_ptr.
    always_comb begin
        w_idx  = '0;
        w_pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i >= NREQ) ? IW'(int'(r_ptr) + i - NREQ) : IW'(int'(r_ptr) + i);
            if (cli_req[w_idx]) w_pick = w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Completion takes priority over the watchdog terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_xfer      = 1'b0;
        w_cap       = 1'b0;
        w_abort     = 1'b0;
        w_tc        = (r_cnt == CW'(TIMEOUT - 1));
        case (r_state)
            IDLE: begin
                w_grant     = |cli_req;
                w_state_nxt = w_grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                w_xfer      = mul_rdy;
                w_abort     = !mul_rdy && w_tc;
                w_state_nxt = w_xfer ? WAIT : (w_abort ? IDLE : ISSUE);
            end
            WAIT: begin
                w_cap       = mul_done;
                w_abort     = !mul_done && w_tc;
                w_state_nxt = w_cap ? RESP : (w_abort ? IDLE : WAIT);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            cli_gnt  <= '0;
            cli_done <= '0;
            cli_ab   <= '0;
            err      <= 1'b0;
            mul_req  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else begin
            cli_gnt  <= w_grant ? NREQ'(1) << w_pick : '0;
            cli_done <= w_cap ? NREQ'(1) << r_id : '0;
            err      <= w_abort;
            mul_req  <= w_grant || (mul_req && !w_xfer && !w_abort);
            r_cnt    <= (w_grant || w_xfer) ? '0 : r_cnt + 1'b1;
            if (w_cap) cli_ab <= mul_ab;
            if (w_grant) begin
                r_id  <= w_pick;
                r_ptr <= (w_pick == IW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
                mul_a <= cli_a[int'(w_pick)*WIDTH +: WIDTH];
                mul_b <= cli_b[int'(w_pick)*WIDTH +: WIDTH];
            end
        end
    end

    assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed and random transactions against a round-robin
// reference model with a behavioural multiplier driving the handshake.
module tb_mul_share_arbiter;
    localparam int W = 5;
    localparam int N = 4;
    localparam int T = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     cli_req = '0;
    logic [N*W-1:0]   cli_a = '0;
    logic [N*W-1:0]   cli_b = '0;
    logic [N-1:0]     cli_gnt, cli_done;
    logic [2*W-1:0]   cli_ab;
    logic             err, busy, mul_req;
    logic             mul_rdy = 1'b0;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_done = 1'b0;
    logic [2*W-1:0]   mul_ab = '0;

    int               errors = 0;
    int               checks = 0;
    int               m_ptr = 0;
    logic [2*W-1:0]   m_ab = '0;
    logic [W-1:0]     opa[N];
    logic [W-1:0]     opb[N];

    always #5 clk = ~clk;

    mul_share_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_a(cli_a), .cli_b(cli_b),
        .cli_gnt(cli_gnt), .cli_done(cli_done), .cli_ab(cli_ab), .err(err), .busy(busy),
        .mul_req(mul_req), .mul_rdy(mul_rdy), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_ab(mul_ab)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (((r >> ((m_ptr + i) % N)) & 1) != 0) return (m_ptr + i) % N;
        return -1;
    endfunction

    task automatic pack;
        for (int i = 0; i < N; i++) begin
            cli_a[i*W +: W] = opa[i];
            cli_b[i*W +: W] = opb[i];
        end
    endtask

    // One full transaction; tmo=1 means the multiplier never completes.
    task automatic txn(input logic [N-1:0] req, input int rdy_dly, input int done_dly, input bit tmo);
        int w;
        logic [W-1:0] ca, cb;
        logic [2*W-1:0] prod;
        w = pick(req);
        pack();
        cli_req = req;
        tick();
        cli_req = '0;
        chk("gnt", 32'(cli_gnt), 32'(1 << w));
        chk("mul_req_up", 32'(mul_req), 1);
        chk("mul_a", 32'(mul_a), 32'(opa[w]));
        chk("mul_b", 32'(mul_b), 32'(opb[w]));
        chk("busy_issue", 32'(busy), 1);
        m_ptr = (w + 1) % N;
        for (int d = 0; d < rdy_dly; d++) begin
            tick();
            chk("hold_req", 32'(mul_req), 1);
            chk("hold_a", 32'(mul_a), 32'(opa[w]));
            chk("no_regnt", 32'(cli_gnt), 0);
        end
        ca = mul_a;
        cb = mul_b;
        mul_rdy = 1'b1;
        tick();
        mul_rdy = 1'b0;
        chk("req_drop", 32'(mul_req), 0);
        if (!tmo) begin
            for (int d = 0; d < done_dly; d++) begin
                tick();
                chk("wait_nodone", 32'(cli_done), 0);
            end
            mul_done = 1'b1;
            mul_ab = (2*W)'(ca) * (2*W)'(cb);
            tick();
            mul_done = 1'b0;
            mul_ab = (2*W)'($urandom);
            prod = (2*W)'(opa[w]) * (2*W)'(opb[w]);
            m_ab = prod;
            chk("done", 32'(cli_done), 32'(1 << w));
            chk("ab", 32'(cli_ab), 32'(m_ab));
            chk("no_err", 32'(err), 0);
            tick();
            chk("done_pulse", 32'(cli_done), 0);
            chk("idle", 32'(busy), 0);
        end else begin
            repeat (T - 1) tick();
            chk("err_early", 32'(err), 0);
            tick();
            chk("err", 32'(err), 1);
            chk("tmo_nodone", 32'(cli_done), 0);
            chk("tmo_ab", 32'(cli_ab), 32'(m_ab));
            chk("tmo_idle", 32'(busy), 0);
            tick();
            chk("err_pulse", 32'(err), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            opa[i] = W'(i + 1);
            opb[i] = W'(3);
        end
        tick();
        tick();
        chk("rst_gnt", 32'(cli_gnt), 0);
        chk("rst_done", 32'(cli_done), 0);
        chk("rst_ab", 32'(cli_ab), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mreq", 32'(mul_req), 0);
        chk("rst_ma", 32'(mul_a), 0);
        chk("rst_mb", 32'(mul_b), 0);
        rst_n = 1'b1;
        tick();
        repeat (5) txn(4'hF, 0, 1, 1'b0);
        opa[2] = 5'd31;
        opb[2] = 5'd31;
        txn(4'b0100, 0, 5, 1'b0);
        chk("ab_961", 32'(cli_ab), 961);
        txn(4'b0010, 0, 0, 1'b0);
        txn(4'b1001, 0, 2, 1'b0);
        txn(4'b0110, 3, 1, 1'b0);
        txn(4'b0101, 1, T - 1, 1'b0);
        txn(4'b1010, 0, 0, 1'b1);
        txn(4'b1111, 0, 3, 1'b0);
        mul_done = 1'b1;
        mul_ab = (2*W)'(~m_ab);
        tick();
        mul_done = 1'b0;
        chk("spur_ab", 32'(cli_ab), 32'(m_ab));
        chk("spur_done", 32'(cli_done), 0);
        chk("spur_busy", 32'(busy), 0);
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                opa[i] = W'($urandom_range(0, 31));
                opb[i] = W'($urandom_range(0, 31));
            end
            txn(N'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, 8), ($urandom_range(0, 9) == 0));
        end
        opa[2] = 5'd7;
        opb[2] = 5'd9;
        m_ptr = 0;
        pack();
        cli_req = 4'b0100;
        tick();
        cli_req = '0;
        mul_rdy = 1'b1;
        tick();
        mul_rdy = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ab", 32'(cli_ab), 0);
        chk("arst_ma", 32'(mul_a), 0);
        chk("arst_mreq", 32'(mul_req), 0);
        tick();
        rst_n = 1'b1;
        tick();
        mul_done = 1'b1;
        mul_ab = 10'd63;
        tick();
        mul_done = 1'b0;
        chk("late_done", 32'(cli_done), 0);
        chk("late_ab", 32'(cli_ab), 0);
        chk("late_err", 32'(err), 0);
        m_ab = '0;
        txn(4'b0011, 0, 1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
